// File: rtl/ladybird_config.sv
// ladybird platform constants: ACLINT bases, per-register offsets, the decoder's register
// enum and small helpers shared by the ACLINT responder.
package ladybird_config;

   localparam logic [31:0] ACLINT_MSIP_BASE     = 32'h0200_0000;
   localparam logic [31:0] ACLINT_MTIMECMP_BASE = 32'h0200_4000;
   localparam logic [31:0] ACLINT_SETSSIP_BASE  = 32'h0200_8000;
   localparam logic [31:0] ACLINT_MTIME_BASE    = 32'h0200_BFF8;

   localparam logic [31:0] ACLINT_MSIP_OFFSET        = 32'h0000_0000;
   localparam logic [31:0] ACLINT_MTIMECMP_OFFSET    = 32'h0000_4000;
   localparam logic [31:0] ACLINT_MTIMECMP_HI_OFFSET = 32'h0000_4004;
   localparam logic [31:0] ACLINT_SETSSIP_OFFSET     = 32'h0000_8000;
   localparam logic [31:0] ACLINT_MTIME_OFFSET       = 32'h0000_BFF8;
   localparam logic [31:0] ACLINT_MTIME_HI_OFFSET    = 32'h0000_BFFC;

   typedef enum logic [2:0] {
      ACLINT_REG_NONE,
      ACLINT_REG_MSIP,
      ACLINT_REG_MTIMECMP_LO,
      ACLINT_REG_MTIMECMP_HI,
      ACLINT_REG_SETSSIP,
      ACLINT_REG_MTIME_LO,
      ACLINT_REG_MTIME_HI
   } aclint_reg_t;

   typedef enum logic {
      ACLINT_IDLE,
      ACLINT_RESP
   } aclint_state_t;

   function automatic aclint_reg_t aclint_decode(input logic [29:0] word_off);
      logic [31:0] off;
      off = {word_off, 2'b00};
      case (off)
         ACLINT_MSIP_OFFSET:        return ACLINT_REG_MSIP;
         ACLINT_MTIMECMP_OFFSET:    return ACLINT_REG_MTIMECMP_LO;
         ACLINT_MTIMECMP_HI_OFFSET: return ACLINT_REG_MTIMECMP_HI;
         ACLINT_SETSSIP_OFFSET:     return ACLINT_REG_SETSSIP;
         ACLINT_MTIME_OFFSET:       return ACLINT_REG_MTIME_LO;
         ACLINT_MTIME_HI_OFFSET:    return ACLINT_REG_MTIME_HI;
         default:                   return ACLINT_REG_NONE;
      endcase
   endfunction

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ladybird_aclint_mtime.sv
// mtime prescaler and 64-bit counter with a per-half store port; registers the
// unsigned mtime >= mtimecmp compare as the machine timer interrupt.
module ladybird_aclint_mtime
   import ladybird_config::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic [63:0] mtimecmp,
   output logic [63:0] mtime,
   output logic        mtip
);

   logic [31:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic        mtip_q;
   logic        tick;

   assign tick = (presc_q == 32'(TICK_DIV - 1));

   // A store in a tick cycle suppresses the increment entirely, so the
   // unwritten half never sees a carry from the written one.
   always_comb begin
      presc_d = tick ? '0 : presc_q + 32'd1;
      mtime_d = mtime_q;
      if (wr_lo || wr_hi) begin
         if (wr_lo) mtime_d[31:0]  = strb_merge(mtime_q[31:0], wdata, wstrb);
         if (wr_hi) mtime_d[63:32] = strb_merge(mtime_q[63:32], wdata, wstrb);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         presc_q <= '0;
         mtime_q <= '0;
         mtip_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
         mtip_q  <= (mtime_q >= mtimecmp);
      end
   end

   assign mtime = mtime_q;
   assign mtip  = mtip_q;

endmodule

// File: rtl/ladybird_aclint.sv
// ACLINT responder (MSWI, MTIMER, SSWI) for a single hart: one outstanding word
// request, response one cycle after accept, back-to-back when resp_ready is high.
//
// state       | meaning
// ACLINT_IDLE | no response pending, request accepted unconditionally
// ACLINT_RESP | resp_valid high, resp_data held until resp_ready
module ladybird_aclint
   import ladybird_config::*;
#(
   parameter int unsigned TICK_DIV  = 1,
   parameter logic [31:0] BASE_ADDR = ACLINT_MSIP_BASE
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_strb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        msip,
   output logic        mtip,
   output logic        ssip
);

   aclint_state_t state_q;
   aclint_reg_t   reg_sel;
   logic [31:0]   resp_data_q, rdata;
   logic [63:0]   mtimecmp_q, mtime_cur;
   logic          msip_q, ssip_q;
   logic          accept, wr_en, byte0_wr;
   logic          unused_addr;

   assign unused_addr = ^req_addr[1:0];
   assign req_ready   = (state_q == ACLINT_IDLE) || resp_ready;
   assign accept      = req_valid && req_ready;
   assign wr_en       = accept && req_we;
   assign byte0_wr    = wr_en && req_strb[0];
   assign reg_sel     = aclint_decode(req_addr[31:2] - BASE_ADDR[31:2]);

   always_comb begin
      rdata = '0;
      case (reg_sel)
         ACLINT_REG_MSIP:        rdata = {31'd0, msip_q};
         ACLINT_REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
         ACLINT_REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
         ACLINT_REG_MTIME_LO:    rdata = mtime_cur[31:0];
         ACLINT_REG_MTIME_HI:    rdata = mtime_cur[63:32];
         default:                rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ACLINT_IDLE;
         resp_data_q <= '0;
         msip_q      <= 1'b0;
         ssip_q      <= 1'b0;
         mtimecmp_q  <= '1;
      end else begin
         ssip_q <= byte0_wr && (reg_sel == ACLINT_REG_SETSSIP) && req_wdata[0];
         if (byte0_wr && (reg_sel == ACLINT_REG_MSIP)) msip_q <= req_wdata[0];
         if (wr_en && (reg_sel == ACLINT_REG_MTIMECMP_LO))
            mtimecmp_q[31:0] <= strb_merge(mtimecmp_q[31:0], req_wdata, req_strb);
         if (wr_en && (reg_sel == ACLINT_REG_MTIMECMP_HI))
            mtimecmp_q[63:32] <= strb_merge(mtimecmp_q[63:32], req_wdata, req_strb);
         if (accept) begin
            state_q     <= ACLINT_RESP;
            resp_data_q <= req_we ? 32'd0 : rdata;
         end else if (resp_ready) begin
            state_q <= ACLINT_IDLE;
         end
      end
   end

   ladybird_aclint_mtime #(
      .TICK_DIV (TICK_DIV)
   ) u_mtime (
      .clk      (clk),
      .nrst     (nrst),
      .wr_lo    (wr_en && (reg_sel == ACLINT_REG_MTIME_LO)),
      .wr_hi    (wr_en && (reg_sel == ACLINT_REG_MTIME_HI)),
      .wdata    (req_wdata),
      .wstrb    (req_strb),
      .mtimecmp (mtimecmp_q),
      .mtime    (mtime_cur),
      .mtip     (mtip)
   );

   assign resp_valid = (state_q == ACLINT_RESP);
   assign resp_data  = resp_data_q;
   assign msip       = msip_q;
   assign ssip       = ssip_q;

endmodule

// File: tb/tb_ladybird_aclint.sv
// Directed bench for ladybird_aclint: requests push expected load data into a
// scoreboard queue, a negedge monitor pops and compares each consumed response.
module tb_ladybird_aclint;

   localparam logic [31:0] B = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_data;
   logic        msip, mtip, ssip;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int e0 = 0;

   typedef struct {
      string       name;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   ladybird_aclint #(
      .TICK_DIV  (1),
      .BASE_ADDR (B)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .msip       (msip),
      .mtip       (mtip),
      .ssip       (ssip)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst && resp_valid && resp_ready) begin
         exp_t e;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp got=%h exp=none", resp_data);
         end else begin
            e = sb.pop_front();
            check(e.name, resp_data, e.data);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the accepting edge with req_valid still high.
   task automatic do_req(input string name, input logic [31:0] off, input logic we,
                         input logic [31:0] wd, input logic [3:0] st, input logic [31:0] exp);
      exp_t e;
      req_valid = 1'b1;
      req_addr  = B + off;
      req_we    = we;
      req_wdata = wd;
      req_strb  = st;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready) begin
            e.name = name;
            e.data = exp;
            sb.push_back(e);
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      failures++;
      $display("FAIL %s got=no_accept exp=accept", name);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      for (int k = 0; k < 200; k++) begin
         if (cyc >= target) return;
         @(posedge clk);
         #1;
      end
      checks++;
      failures++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, target);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_msip", msip, 0);
      check("rst_ssip", ssip, 0);
      check("rst_mtip", mtip, 0);

      nrst = 1'b1;
      do_req("rd_mtime_lo_rst", 32'hBFF8, 0, 0, 4'h0, 32'h0);
      do_req("rd_mtime_hi_rst", 32'hBFFC, 0, 0, 4'h0, 32'h0);
      do_req("rd_cmp_lo_rst",   32'h4000, 0, 0, 4'h0, 32'hFFFF_FFFF);
      do_req("rd_cmp_hi_rst",   32'h4004, 0, 0, 4'h0, 32'hFFFF_FFFF);

      // mtime = k after edge e0+k; compare 0x10 is met after e0+16, mtip follows one edge later
      do_req("wr_mtime_lo0", 32'hBFF8, 1, 32'h0, 4'hF, 32'h0);
      e0 = cyc;
      do_req("wr_cmp_hi0",   32'h4004, 1, 32'h0, 4'hF, 32'h0);
      do_req("wr_cmp_lo10",  32'h4000, 1, 32'h10, 4'hF, 32'h0);
      idle();
      wait_cyc(e0 + 16);
      check("mtip_before", mtip, 0);
      @(posedge clk);
      #1;
      check("mtip_rise", mtip, 1);
      repeat (10) @(posedge clk);
      #1;
      check("mtip_hold", mtip, 1);

      do_req("wr_hi0",      32'hBFFC, 1, 32'h0, 4'hF, 32'h0);
      do_req("wr_lo_max",   32'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, 32'h0);
      do_req("rd_hi_pre",   32'hBFFC, 0, 0, 4'h0, 32'h0);
      do_req("rd_hi_carry", 32'hBFFC, 0, 0, 4'h0, 32'h1);
      do_req("rd_lo_after", 32'hBFF8, 0, 0, 4'h0, 32'h1);
      do_req("wr_lo5",        32'hBFF8, 1, 32'h5, 4'hF, 32'h0);
      do_req("wr_hi_tick",    32'hBFFC, 1, 32'hABCD_0000, 4'hF, 32'h0);
      do_req("rd_lo_held",    32'hBFF8, 0, 0, 4'h0, 32'h5);
      do_req("rd_hi_written", 32'hBFFC, 0, 0, 4'h0, 32'hABCD_0000);
      do_req("wr_hi_max",  32'hBFFC, 1, 32'hFFFF_FFFF, 4'hF, 32'h0);
      do_req("wr_lo_max2", 32'hBFF8, 1, 32'hFFFF_FFFF, 4'hF, 32'h0);
      do_req("rd_lo_max",  32'hBFF8, 0, 0, 4'h0, 32'hFFFF_FFFF);
      do_req("rd_hi_wrap", 32'hBFFC, 0, 0, 4'h0, 32'h0);
      do_req("wr_cmp_hi_strb", 32'h4004, 1, 32'h1234_5678, 4'b0101, 32'h0);
      do_req("rd_cmp_hi_strb", 32'h4004, 0, 0, 4'h0, 32'h0034_0078);
      do_req("rd_cmp_lo",      32'h4000, 0, 0, 4'h0, 32'h10);
      idle();

      do_req("wr_msip_b1", 32'h0, 1, 32'h1, 4'b0010, 32'h0);
      idle();
      check("msip_strb_off", msip, 0);
      do_req("wr_msip_b0", 32'h0, 1, 32'h1, 4'b0001, 32'h0);
      idle();
      check("msip_set", msip, 1);
      do_req("wr_ssip", 32'h8000, 1, 32'h1, 4'b0001, 32'h0);
      idle();
      check("ssip_pulse", ssip, 1);
      @(posedge clk);
      #1;
      check("ssip_clear", ssip, 0);
      do_req("rd_ssip",     32'h8000, 0, 0, 4'h0, 32'h0);
      do_req("rd_msip",     32'h0,    0, 0, 4'h0, 32'h1);
      do_req("rd_unmapped", 32'h1234, 0, 0, 4'h0, 32'h0);
      idle();
      @(posedge clk);
      #1;

      resp_ready = 1'b0;
      do_req("rd_msip_bp", 32'h0, 0, 0, 4'h0, 32'h1);
      idle();
      repeat (3) begin
         @(negedge clk);
         check("bp_req_ready", req_ready, 0);
         check("bp_resp_valid", resp_valid, 1);
         check("bp_resp_data", resp_data, 32'h1);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;

      resp_ready = 1'b0;
      do_req("rd_dropped", 32'h0, 0, 0, 4'h0, 32'h1);
      idle();
      @(negedge clk);
      check("pre_rst_valid", resp_valid, 1);
      nrst = 1'b0;
      #1;
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_req_ready", req_ready, 1);
      check("midrst_msip", msip, 0);
      check("midrst_mtip", mtip, 0);
      sb.delete();
      @(posedge clk);
      #1;
      nrst = 1'b1;
      resp_ready = 1'b1;
      do_req("rd_cmp_lo_rst2", 32'h4000, 0, 0, 4'h0, 32'hFFFF_FFFF);
      do_req("rd_unmapped2",   32'h1234, 0, 0, 4'h0, 32'h0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
